mem_to_axi_master: RTL

- Bridges a single simple memory-request port (req/gnt, rvalid) onto an AXI4 manager port.
- Each granted request becomes a single-beat AXI transaction. Reads use AR/R; writes use AW/W/B.
- Responses return on the memory port strictly in request order.
- Sits between a core-side/DMA-side mem interface and the AXI crossbar. It is the initiator counterpart to the AXI-to-memory subordinate bridge.

---
 rtl/mem_to_axi_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_to_axi_master.sv
// Simple req/gnt memory port to single-beat AXI4 manager bridge with in-order responses.

package mem_to_axi_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

module mem_to_axi_master #(
    parameter type axi_req_t             = mem_to_axi_pkg::axi_req_t,
    parameter type axi_resp_t            = mem_to_axi_pkg::axi_resp_t,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned IdWidth       = 4,
    parameter logic [IdWidth-1:0] AxiId  = '0,
    parameter int unsigned MaxRequests   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   busy_o,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    input  logic                   mem_lock_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output logic                   mem_exokay_o,
    output axi_req_t               axi_req_o,
    input  axi_resp_t              axi_resp_i
);
    localparam int unsigned SizeLog = $clog2(DataWidth / 8);
    localparam int unsigned PtrW    = (MaxRequests > 1) ? $clog2(MaxRequests) : 1;
    localparam int unsigned CntW    = $clog2(MaxRequests + 1);
    localparam logic [1:0]  RespExOkay = 2'b01;

    logic                   aw_valid_q, w_valid_q, ar_valid_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   data_q;
    logic [DataWidth/8-1:0] strb_q;
    logic                   lock_q;

    logic [MaxRequests-1:0] fifo_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        cnt_q;

    logic       gnt, r_ready, b_ready, r_hs, b_hs, rsp, head_we, empty;
    logic [1:0] rsp_code;

    assign empty   = (cnt_q == '0);
    assign head_we = fifo_q[rd_ptr_q];
    assign gnt     = !rst_i && mem_req_i && (cnt_q < CntW'(MaxRequests))
                     && !(aw_valid_q || w_valid_q || ar_valid_q);
    assign r_ready = !empty && !head_we;
    assign b_ready = !empty && head_we;
    assign r_hs    = axi_resp_i.r_valid && r_ready;
    assign b_hs    = axi_resp_i.b_valid && b_ready;
    assign rsp     = r_hs || b_hs;
    assign rsp_code = r_hs ? axi_resp_i.r.resp : axi_resp_i.b.resp;

    assign mem_gnt_o    = gnt;
    assign mem_rvalid_o = rsp;
    assign mem_rdata_o  = r_hs ? axi_resp_i.r.data : '0;
    assign mem_err_o    = rsp && rsp_code[1];
    assign mem_exokay_o = rsp && (rsp_code == RespExOkay);
    assign busy_o       = !empty || aw_valid_q || w_valid_q || ar_valid_q;

    // Request stage: capture payload on grant, drop each valid on its own ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            lock_q     <= 1'b0;
        end else begin
            if (aw_valid_q && axi_resp_i.aw_ready) aw_valid_q <= 1'b0;
            if (w_valid_q && axi_resp_i.w_ready)   w_valid_q  <= 1'b0;
            if (ar_valid_q && axi_resp_i.ar_ready) ar_valid_q <= 1'b0;
            if (gnt) begin
                addr_q <= mem_addr_i;
                data_q <= mem_wdata_i;
                strb_q <= mem_strb_i;
                lock_q <= mem_lock_i;
                if (mem_we_i) begin
                    aw_valid_q <= 1'b1;
                    w_valid_q  <= 1'b1;
                end else begin
                    ar_valid_q <= 1'b1;
                end
            end
        end
    end

    // Order FIFO of read/write kind; its occupancy doubles as the outstanding counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (gnt) begin
                fifo_q[wr_ptr_q] <= mem_we_i;
                wr_ptr_q <= (wr_ptr_q == PtrW'(MaxRequests - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rsp) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(MaxRequests - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (gnt && !rsp)      cnt_q <= cnt_q + 1'b1;
            else if (!gnt && rsp) cnt_q <= cnt_q - 1'b1;
        end
    end

    // AXI request assembly from the registered request stage
    always_comb begin
        axi_req_o            = '0;
        axi_req_o.aw.id      = AxiId;
        axi_req_o.aw.addr    = addr_q;
        axi_req_o.aw.size    = 3'(SizeLog);
        axi_req_o.aw.burst   = 2'b01;
        axi_req_o.aw.lock    = lock_q;
        axi_req_o.aw_valid   = aw_valid_q;
        axi_req_o.w.data     = data_q;
        axi_req_o.w.strb     = strb_q;
        axi_req_o.w.last     = 1'b1;
        axi_req_o.w_valid    = w_valid_q;
        axi_req_o.b_ready    = b_ready;
        axi_req_o.ar.id      = AxiId;
        axi_req_o.ar.addr    = addr_q;
        axi_req_o.ar.size    = 3'(SizeLog);
        axi_req_o.ar.burst   = 2'b01;
        axi_req_o.ar.lock    = lock_q;
        axi_req_o.ar_valid   = ar_valid_q;
        axi_req_o.r_ready    = r_ready;
    end

    logic unused_resp;
    assign unused_resp = ^{axi_resp_i.b.user, axi_resp_i.r.user};

    // Subordinate must answer with single-beat responses carrying our ID
    assert property (@(posedge clk_i) disable iff (rst_i)
        axi_resp_i.r_valid |-> (axi_resp_i.r.last && (axi_resp_i.r.id == AxiId)));
    assert property (@(posedge clk_i) disable iff (rst_i)
        axi_resp_i.b_valid |-> (axi_resp_i.b.id == AxiId));

endmodule
